// File: rtl/pong_pkg.sv
// Shared encodings for the Pong button conditioner: paddle direction codes and FSM states.
// The FSM state encoding equals the direction code, so move_dir is the state register itself.
package pong_pkg;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = DIR_NONE,
    ST_LEFT  = DIR_LEFT,
    ST_RIGHT = DIR_RIGHT
  } dir_state_e;

endpackage

// File: rtl/pong_debounce.sv
// One button channel: 2-flop synchroniser, inversion to active-high, counter debounce and
// press edge pulse. Optional auto-repeat of the pulse is built only with PONG_BTN_REPEAT_EN.
module pong_debounce #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int CNT_W           = 17,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_n_i,
  output logic pressed_o,
  output logic edge_o,
  output logic pulse_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Out-of-range parameters have no meaningful behaviour; this block just names that range.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
  end

  logic             sync1_q;
  logic             sync2_q;
  logic             level;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             edge_q;
  logic             edge_d;

  assign level = ~sync2_q;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    edge_d   = 1'b0;
    if (level == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = level;
      cnt_d    = '0;
      edge_d   = level;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      edge_q   <= 1'b0;
    end else begin
      sync1_q  <= button_n_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
    end
  end

  assign pressed_o = stable_q;
  assign edge_o    = edge_q;

`ifdef PONG_BTN_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt_q;
  logic [REP_W-1:0] rep_cnt_d;
  logic             first_q;
  logic             first_d;
  logic             rep_q;
  logic             rep_d;

  // Counter is 0 in the press-pulse cycle, so a hit at DELAY_LAST lands the repeat exactly
  // REPEAT_DELAY cycles after it; a repeat is suppressed if the button releases on that edge.
  always_comb begin
    rep_cnt_d = '0;
    first_d   = 1'b1;
    rep_d     = 1'b0;
    if (stable_q) begin
      first_d = first_q;
      if (rep_cnt_q == (first_q ? DELAY_LAST : PERIOD_LAST)) begin
        rep_cnt_d = '0;
        first_d   = 1'b0;
        rep_d     = stable_d;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt_q <= '0;
      first_q   <= 1'b1;
      rep_q     <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      first_q   <= first_d;
      rep_q     <= rep_d;
    end
  end

  assign pulse_o = edge_q | rep_q;
`else
  assign pulse_o = edge_q;
`endif

endmodule

// File: rtl/pong_button_conditioner.sv
// Pong paddle input stage: two debounced button channels plus the paddle direction FSM.
// Build with PONG_BTN_REPEAT_EN to get auto-repeating press pulses while a button is held.
module pong_button_conditioner
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int CNT_W           = 17,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_left_n,
  input  logic       button_right_n,
  output logic       left_pressed,
  output logic       right_pressed,
  output logic       left_pulse,
  output logic       right_pulse,
  output logic [1:0] move_dir
);

  logic left_edge;
  logic right_edge;

  pong_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_left (
    .clk       (clk),
    .reset     (reset),
    .button_n_i(button_left_n),
    .pressed_o (left_pressed),
    .edge_o    (left_edge),
    .pulse_o   (left_pulse)
  );

  pong_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_right (
    .clk       (clk),
    .reset     (reset),
    .button_n_i(button_right_n),
    .pressed_o (right_pressed),
    .edge_o    (right_edge),
    .pulse_o   (right_pulse)
  );

  dir_state_e state_q;
  dir_state_e state_d;

  // The FSM sees only true press edges, so auto-repeat pulses never steal the direction.
  // In IDLE a lone held button can only follow a both-held period, and it wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (left_pressed && !right_pressed) begin
          state_d = ST_LEFT;
        end else if (right_pressed && !left_pressed) begin
          state_d = ST_RIGHT;
        end
      end
      ST_LEFT: begin
        if (right_edge) begin
          state_d = ST_RIGHT;
        end else if (!left_pressed) begin
          state_d = right_pressed ? ST_RIGHT : ST_IDLE;
        end
      end
      ST_RIGHT: begin
        if (left_edge) begin
          state_d = ST_LEFT;
        end else if (!right_pressed) begin
          state_d = left_pressed ? ST_LEFT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign move_dir = state_q;

endmodule

// File: tb/tb_pong_button_conditioner.sv
// Randomised scoreboard bench for pong_button_conditioner with a window-based reference model.
module tb_pong_button_conditioner;

  localparam int DC = 8;
  localparam int RD = 20;
  localparam int RP = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       button_left_n = 1'b1;
  logic       button_right_n = 1'b1;
  logic       left_pressed;
  logic       right_pressed;
  logic       left_pulse;
  logic       right_pulse;
  logic [1:0] move_dir;

  pong_button_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (4),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .button_left_n (button_left_n),
    .button_right_n(button_right_n),
    .left_pressed  (left_pressed),
    .right_pressed (right_pressed),
    .left_pulse    (left_pulse),
    .right_pulse   (right_pulse),
    .move_dir      (move_dir)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [5:0] exp_q[$];
  logic started = 1'b0;
  logic stop    = 1'b0;

  // reference model: a button flips once its last DC synchronised samples all disagree
  logic          dl_l[$];
  logic          dl_r[$];
  logic [DC-1:0] win_l, win_r;
  logic          st_l, st_r;
  logic          p_lp, p_rp, p_el, p_er;
  logic [1:0]    dir_m;
  int            cyc = 0;
  int            press_l = 0;
  int            press_r = 0;

  function automatic logic repeat_due(input int now, input int pressed_at, input logic held,
                                      input logic is_edge);
    int dt;
    dt = now - pressed_at;
`ifdef PONG_BTN_REPEAT_EN
    return held && !is_edge && dt >= RD && ((dt - RD) % RP) == 0;
`else
    return 1'b0 && held && is_edge && dt >= 0;
`endif
  endfunction

  always @(posedge clk) begin
    logic sl, sr, el, er, pl, pr;
    logic [1:0] nd;
    cyc++;
    if (reset) begin
      dl_l = '{1'b1, 1'b1};
      dl_r = '{1'b1, 1'b1};
      win_l = '0; win_r = '0;
      st_l = 1'b0; st_r = 1'b0;
      p_lp = 1'b0; p_rp = 1'b0; p_el = 1'b0; p_er = 1'b0;
      dir_m = 2'b00;
      started = 1'b1;
      if (!stop) exp_q.push_back(6'b0);
    end else if (started) begin
      sl = !dl_l.pop_front(); dl_l.push_back(button_left_n);
      sr = !dl_r.pop_front(); dl_r.push_back(button_right_n);
      win_l = {win_l[DC-2:0], sl};
      win_r = {win_r[DC-2:0], sr};
      el = 1'b0; er = 1'b0;
      if (win_l == {DC{~st_l}}) begin st_l = ~st_l; el = st_l; end
      if (win_r == {DC{~st_r}}) begin st_r = ~st_r; er = st_r; end
      if (el) press_l = cyc;
      if (er) press_r = cyc;
      pl = el | repeat_due(cyc, press_l, st_l, el);
      pr = er | repeat_due(cyc, press_r, st_r, er);
      // direction from last cycle's levels and true press edges
      nd = dir_m;
      case (dir_m)
        2'b00: begin
          if (p_el && !p_rp) nd = 2'b01;
          else if (p_er && !p_lp) nd = 2'b10;
          else if (p_lp && !p_rp) nd = 2'b01;
          else if (p_rp && !p_lp) nd = 2'b10;
        end
        2'b01: begin
          if (p_er) nd = 2'b10;
          else if (!p_lp) nd = p_rp ? 2'b10 : 2'b00;
        end
        default: begin
          if (p_el) nd = 2'b01;
          else if (!p_rp) nd = p_lp ? 2'b01 : 2'b00;
        end
      endcase
      dir_m = nd;
      p_lp = st_l; p_rp = st_r; p_el = el; p_er = er;
      if (!stop) exp_q.push_back({st_l, st_r, pl, pr, dir_m});
    end
  end

  // scoreboard monitor
  task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, got, exp);
  endtask

  always @(negedge clk) begin
    logic [5:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pressed", {left_pressed, right_pressed}, e[5:4]);
      check("pulse",   {left_pulse, right_pulse},     e[3:2]);
      check("move_dir", move_dir,                     e[1:0]);
    end
  end

  // driver tasks
  task automatic drive(input logic l_n, input logic r_n, input int n);
    button_left_n  = l_n;
    button_right_n = r_n;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // clean left press and release
    drive(1'b0, 1'b1, 14);
    drive(1'b1, 1'b1, 14);
    // bouncing left press
    drive(1'b0, 1'b1, 5);
    drive(1'b1, 1'b1, 1);
    drive(1'b0, 1'b1, 3);
    drive(1'b0, 1'b1, 14);
    drive(1'b1, 1'b1, 14);
    // left held, right pressed then released
    drive(1'b0, 1'b1, 14);
    drive(1'b0, 1'b0, 14);
    drive(1'b0, 1'b1, 14);
    drive(1'b1, 1'b1, 14);
    // both pressed together, then right released
    drive(1'b0, 1'b0, 14);
    drive(1'b0, 1'b1, 14);
    drive(1'b1, 1'b1, 14);
    // reset while left held and right bouncing
    drive(1'b0, 1'b1, 14);
    drive(1'b0, 1'b0, 3);
    drive(1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 1);
    pulse_reset(1);
    drive(1'b0, 1'b1, 14);
    drive(1'b1, 1'b1, 14);
    // long right hold (repeat pulses in the repeat build)
    drive(1'b1, 1'b0, 60);
    drive(1'b1, 1'b1, 14);
    // random segments
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 15) == 0) pulse_reset($urandom_range(1, 2));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 30));
    end
    drive(1'b1, 1'b1, 14);
    stop = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
